// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router, with a header-tagged store and a read-side packet counter.
// Define ROUTER_FIFO_OVF_FLAG_EN to build the sticky write-while-full overflow flag.
module router_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [6:0]       r_pkt_cnt;
    logic [WIDTH-1:0] r_data_out;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH:0]   w_rd_word;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_en   = write_enb && !full;
    assign w_rd_en   = read_enb && !empty;
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
    assign data_out  = r_data_out;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else if (soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
                r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd_en) begin
                r_data_out <= w_rd_word[WIDTH-1:0];
                r_rd_ptr   <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                // Header byte carries payload length in bits 7:2; +1 accounts for parity.
                if (w_rd_word[WIDTH]) begin
                    r_pkt_cnt <= {1'b0, w_rd_word[7:2]} + 7'd1;
                end else if (r_pkt_cnt != 7'd0) begin
                    r_pkt_cnt <= r_pkt_cnt - 7'd1;
                end
            end else if (r_pkt_cnt == 7'd0) begin
                r_data_out <= '0;
            end
        end
    end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (soft_reset) begin
            r_overflow <= 1'b0;
        end else if (write_enb && full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_router_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clock;
    logic             resetn;
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;
    logic             overflow;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of {tag, byte} entries plus packet bookkeeping.
    logic [8:0]  m_q [$];
    int unsigned m_cnt  = 0;
    logic [7:0]  m_dout = '0;
    bit          m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rn, input bit sr, input bit we, input bit re,
                              input bit lfd, input logic [7:0] din);
        bit          m_full;
        bit          m_empty;
        logic [8:0]  w;
        if (!rn || sr) begin
            m_q.delete();
            m_cnt  = 0;
            m_dout = '0;
            m_ovf  = 1'b0;
        end else begin
            m_full  = (m_q.size() == DEPTH);
            m_empty = (m_q.size() == 0);
            if (we && m_full && OVF_EN) m_ovf = 1'b1;
            if (re && !m_empty) begin
                w      = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8])            m_cnt = int'(w[7:2]) + 1;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = '0;
            end
            if (we && !m_full) m_q.push_back({lfd, din});
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic step(input bit rn, input bit sr, input bit we, input bit re,
                        input bit lfd, input logic [7:0] din);
        resetn     = rn;
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        @(posedge clock);
        model_edge(rn, sr, we, re, lfd, din);
        #1;
        chk("model_full",     {31'd0, full},      {31'd0, m_q.size() == DEPTH});
        chk("model_empty",    {31'd0, empty},     {31'd0, m_q.size() == 0});
        chk("model_data_out", {24'd0, data_out},  {24'd0, m_dout});
        chk("model_overflow", {31'd0, overflow},  {31'd0, m_ovf});
    endtask

    typedef struct {
        bit         rn;
        bit         we;
        bit         re;
        bit         lfd;
        logic [7:0] din;
        bit         e_full;
        bit         e_empty;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs [14];

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = '0;

        //          rn  we  re  lfd din     full empty dout
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h5F, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0D};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA3};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5F};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};

        #1;
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rn, 1'b0, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
            chk($sformatf("vec%0d_full", i),  {31'd0, full},     {31'd0, vecs[i].e_full});
            chk($sformatf("vec%0d_empty", i), {31'd0, empty},    {31'd0, vecs[i].e_empty});
            chk($sformatf("vec%0d_dout", i),  {24'd0, data_out}, {24'd0, vecs[i].e_dout});
        end
        chk("reset_overflow", {31'd0, overflow}, 32'd0);

        // Fill, drop on full, drain, then wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        chk("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("drop_full", {31'd0, full}, 32'd1);
        chk("drop_overflow", {31'd0, overflow}, {31'd0, OVF_EN});
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_order", {24'd0, data_out}, 32'h30 + 32'(i));
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("wrap_order", {24'd0, data_out}, 32'hC0 + 32'(i));
        end
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Simultaneous read and write while full: only the read proceeds.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
        chk("simul_dout", {24'd0, data_out}, 32'h50);
        chk("simul_not_full", {31'd0, full}, 32'd0);
        chk("simul_count", 32'(m_q.size()), 32'd15);

        // Soft reset with 5 stored and a packet mid-read.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("hold_dout", {24'd0, data_out}, 32'h10);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42);
        chk("soft_empty", {31'd0, empty}, 32'd1);
        chk("soft_dout", {24'd0, data_out}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("soft_new_data", {24'd0, data_out}, 32'h77);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 5) == 0),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router: one instance sits downstream of the packet register stage for each of the three output ports. Stores the header, payload and parity bytes that the register stage drives onto its byte output, and tags each header entry with the header-load flag. When a header is read, the block loads a payload-length counter so the read side knows where the packet ends. A destination-side timeout flushes the buffer through a soft reset.

## Interface
- DEPTH, 16: number of entries; power of two, at least 4.
- WIDTH, 8: data byte width; the stored word is WIDTH+1 bits.
- clock  in  1  rising-edge clock for all state.
- resetn  in  1  synchronous active-low reset; highest priority.
- soft_reset  in  1  synchronous flush from the sync/timeout logic; second priority.
- write_enb  in  1  write request, asserted by the router sync block for this port.
- read_enb  in  1  read request from the destination.
- lfd_state  in  1  header-load flag; written into the tag bit alongside data_in.
- data_in  in  WIDTH  byte from the register stage.
- full  out  1  no free entry.
- empty  out  1  no stored entry.
- data_out  out  WIDTH  registered read byte.
- overflow  out  1  sticky write-while-full flag (see Configuration).

## Operation
- Storage: DEPTH x (WIDTH+1) array. Bit WIDTH is the header tag; bits WIDTH-1:0 are the byte.
- Pointers: wr_ptr and rd_ptr are each log2(DEPTH)+1 bits wide. The MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Both flags are combinational from the pointer registers.
- Write: when write_enb && !full, store mem[wr_ptr] <= {lfd_state, data_in} and increment wr_ptr modulo 2*DEPTH.
  - A write while full is dropped; the memory and pointers are unchanged.
- Read: when read_enb && !empty, load data_out <= mem[rd_ptr][WIDTH-1:0] and increment rd_ptr.
- Packet counter: pkt_cnt is 7 bits.
  - A read of a tagged word loads pkt_cnt <= byte[7:2] + 1 (payload length plus parity).
  - A read of an untagged word with pkt_cnt != 0 decrements pkt_cnt.
  - In any cycle with pkt_cnt == 0 and no read, data_out <= 0.
- Simultaneous read and write:
  - Both proceed if allowed by the flags evaluated at the start of the cycle.
  - If full, only the read proceeds. If empty, only the write proceeds.
  - Occupancy stays constant when both proceed.
- soft_reset:
  - Clears wr_ptr, rd_ptr, pkt_cnt and data_out to 0.
  - Memory contents are left unchanged.
  - A write or read in the same cycle is ignored.
- resetn low:
  - Clears the pointers, pkt_cnt and data_out.
  - Clears every memory word to 0.
  - Clears overflow.

## Timing
- Reset values: full=0, empty=1, data_out=0, overflow=0.
- Write-to-visible latency:
  - empty deasserts the cycle after the first accepted write.
  - Data is readable in that following cycle.
- Read latency: data_out is valid one clock after the edge that samples read_enb && !empty.
- full asserts the cycle after the DEPTH-th unread write, and deasserts the cycle after a read.
- Wrap-around: the pointer index wraps from DEPTH-1 to 0 and the wrap bit toggles. This is transparent to the flags.
- Reset mid-packet: all state returns to reset values on the next edge. A partially read packet is discarded.

## Configuration
- ROUTER_FIFO_OVF_FLAG_EN defined:
  - overflow sets on any cycle with write_enb && full && !soft_reset.
  - It stays set until resetn or soft_reset.
- ROUTER_FIFO_OVF_FLAG_EN undefined:
  - overflow is tied to 0 and no flag register is built.
  - All other behaviour is identical.

## Test plan
- Reset: hold resetn low for 2 cycles, then release -> empty=1, full=0, data_out=0, overflow=0.
- Single packet:
  - Stimulus: write header 8'h0D with lfd_state=1, payload bytes 8'hA1, 8'hA2, 8'hA3, then parity 8'h5F; then read continuously.
  - Response: data_out sequence is 0D, A1, A2, A3, 5F. pkt_cnt loads 4 on the header read and reaches 0 after the parity read. data_out returns to 0 on the next idle cycle.
- Fill and wrap:
  - 16 writes -> full=1; a 17th write is dropped.
  - With the macro defined, overflow=1.
  - Read 16 entries in order, then write 3 more and read them back -> correct order across the wrap; empty=1 at the end.
- Simultaneous access: while full, assert read_enb and write_enb together -> one read occurs, the write is dropped, and the entry count becomes 15.
- Soft reset: with 5 entries stored, pulse soft_reset for 1 cycle -> empty=1 and data_out=0 on the next cycle; a subsequent write/read returns the new data.
